// File: rtl/crypto_core_arbiter.sv
// Round-robin arbiter sharing one crypto core between requesters A and B.
// Latches the winner's operands, runs start/wait/done, and aborts via a watchdog.
module crypto_core_arbiter #(
  parameter int TIMEOUT = 1000,
  parameter int TMR_W   = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_a_req,
  input  logic [63:0] i_a_data_in,
  input  logic [63:0] i_a_add,
  input  logic [31:0] i_a_control,
  output logic        o_a_grant,
  output logic [63:0] o_a_data_out,
  output logic        o_a_done,
  output logic        o_a_timeout,
  input  logic        i_b_req,
  input  logic [63:0] i_b_data_in,
  input  logic [63:0] i_b_add,
  input  logic [31:0] i_b_control,
  output logic        o_b_grant,
  output logic [63:0] o_b_data_out,
  output logic        o_b_done,
  output logic        o_b_timeout,
  output logic [63:0] o_core_data_in,
  output logic [63:0] o_core_add,
  output logic [31:0] o_core_control,
  output logic        o_core_start,
  input  logic [63:0] i_core_data_out,
  input  logic        i_core_end_op,
  output logic        o_busy
);

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;
  localparam logic OWN_A = 1'b0;

  state_t           state_reg, state_next;
  logic             owner_reg;
  logic             last_grant_reg;
  logic             timeout_flag_reg;
  logic [TMR_W-1:0] timer_reg;
  logic [63:0]      core_data_in_reg;
  logic [63:0]      core_add_reg;
  logic [31:0]      core_control_reg;
  logic [1:0]       grant_vec, done_vec, timeout_vec;
  logic             any_req, win_b, timer_expired, wait_exit;

  // With both requesting, B wins only if A had the previous grant.
  assign any_req       = i_a_req | i_b_req;
  assign win_b         = i_b_req & (~i_a_req | (last_grant_reg == OWN_A));
  assign timer_expired = (timer_reg == TMR_W'(TIMEOUT - 1));
  assign wait_exit     = i_core_end_op | timer_expired;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (any_req) state_next = START;
      START:   state_next = WAIT;
      WAIT:    if (wait_exit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      owner_reg        <= 1'b0;
      last_grant_reg   <= 1'b1;
      timeout_flag_reg <= 1'b0;
      timer_reg        <= '0;
      core_data_in_reg <= '0;
      core_add_reg     <= '0;
      core_control_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: if (any_req) begin
          owner_reg        <= win_b;
          timeout_flag_reg <= 1'b0;
          core_data_in_reg <= win_b ? i_b_data_in : i_a_data_in;
          core_add_reg     <= win_b ? i_b_add     : i_a_add;
          core_control_reg <= win_b ? i_b_control : i_a_control;
        end
        START: timer_reg <= '0;
        WAIT: if (!i_core_end_op) begin
          // end_op wins over expiry when both land on the last WAIT cycle
          if (timer_expired) timeout_flag_reg <= 1'b1;
          else               timer_reg <= timer_reg + 1'b1;
        end
        DONE: begin
          core_control_reg <= '0;
          last_grant_reg   <= owner_reg;
        end
        default: ;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      logic [63:0] data_out_reg;
      logic        owns;

      assign owns = (owner_reg == 1'(gi));

      always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)
          data_out_reg <= '0;
        else if (state_reg == WAIT && owns && wait_exit)
          data_out_reg <= i_core_end_op ? i_core_data_out : '0;
      end

      assign grant_vec[gi]   = (state_reg == START) & owns;
      assign done_vec[gi]    = (state_reg == DONE) & owns;
      assign timeout_vec[gi] = (state_reg == DONE) & owns & timeout_flag_reg;
    end
  endgenerate

  assign o_a_grant      = grant_vec[0];
  assign o_b_grant      = grant_vec[1];
  assign o_a_done       = done_vec[0];
  assign o_b_done       = done_vec[1];
  assign o_a_timeout    = timeout_vec[0];
  assign o_b_timeout    = timeout_vec[1];
  assign o_a_data_out   = g_req[0].data_out_reg;
  assign o_b_data_out   = g_req[1].data_out_reg;
  assign o_core_data_in = core_data_in_reg;
  assign o_core_add     = core_add_reg;
  assign o_core_control = core_control_reg;
  assign o_core_start   = (state_reg == START);
  assign o_busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_crypto_core_arbiter.sv
// Bench for crypto_core_arbiter: directed vector table, reset/alternation sequences,
// and randomized traffic checked every cycle against a transaction-level model.
module tb_crypto_core_arbiter;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_req = 1'b0, b_req = 1'b0;
  logic [63:0] a_din = '0, a_add = '0, b_din = '0, b_add = '0;
  logic [31:0] a_ctl = '0, b_ctl = '0;
  logic        a_grant, a_done, a_to, b_grant, b_done, b_to;
  logic [63:0] a_dout, b_dout, c_din, c_add, c_dout;
  logic [31:0] c_ctl;
  logic        c_start, c_end, busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int core_lat = 1;
  int dir_lat = 1;
  int rmode = 0;
  int core_cnt = 1000;
  bit rand_lat = 0;

  always #5 clk = ~clk;

  crypto_core_arbiter #(.TIMEOUT(TO), .TMR_W(16)) dut (
    .i_clk(clk), .i_rst(rst_n),
    .i_a_req(a_req), .i_a_data_in(a_din), .i_a_add(a_add), .i_a_control(a_ctl),
    .o_a_grant(a_grant), .o_a_data_out(a_dout), .o_a_done(a_done), .o_a_timeout(a_to),
    .i_b_req(b_req), .i_b_data_in(b_din), .i_b_add(b_add), .i_b_control(b_ctl),
    .o_b_grant(b_grant), .o_b_data_out(b_dout), .o_b_done(b_done), .o_b_timeout(b_to),
    .o_core_data_in(c_din), .o_core_add(c_add), .o_core_control(c_ctl),
    .o_core_start(c_start), .i_core_data_out(c_dout), .i_core_end_op(c_end),
    .o_busy(busy)
  );

  // Behavioural core: end_op rises in the core_lat-th cycle after start (0 = always high).
  always @(posedge clk) begin
    if (c_start) core_cnt <= 1;
    else if (core_cnt < 1000) core_cnt <= core_cnt + 1;
  end
  assign c_end  = (core_lat == 0) || (core_cnt >= core_lat);
  assign c_dout = (rmode == 2) ? 64'hFFFF_FFFF_FFFF_FFFF :
                  (rmode == 1) ? (c_din ^ c_add) : c_din;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Transaction-level model: each operation is a grant cycle and a done cycle.
  initial begin : monitor
    bit          s_rst, s_ra, s_rb;
    logic [63:0] s_adin, s_aadd, s_bdin, s_badd, din;
    logic [31:0] s_actl, s_bctl;
    int          m_grant, m_done, k;
    bit          m_owner, m_last, m_to;
    logic [63:0] m_res, m_adout, m_bdout, m_cdin, m_cadd;
    logic [31:0] m_cctl;
    bit          eg, ed;
    m_grant = -20; m_done = -10; m_owner = 0; m_last = 1; m_to = 0;
    m_res = '0; m_adout = '0; m_bdout = '0; m_cdin = '0; m_cadd = '0; m_cctl = '0;
    forever begin
      @(posedge clk);
      cyc++;
      s_rst = rst_n; s_ra = a_req; s_rb = b_req;
      s_adin = a_din; s_aadd = a_add; s_actl = a_ctl;
      s_bdin = b_din; s_badd = b_add; s_bctl = b_ctl;
      #1;
      if (!s_rst || !rst_n) begin
        m_grant = cyc - 2; m_done = cyc - 1; m_last = 1; m_to = 0;
        m_adout = '0; m_bdout = '0; m_cdin = '0; m_cadd = '0; m_cctl = '0;
      end else begin
        if (cyc - 1 > m_done && (s_ra || s_rb)) begin
          if (s_ra && s_rb) m_owner = (m_last == 0);
          else              m_owner = s_rb;
          if (rand_lat) core_lat = $urandom_range(0, 10);
          else          core_lat = dir_lat;
          k = (core_lat < 1) ? 1 : core_lat;
          m_cdin = m_owner ? s_bdin : s_adin;
          m_cadd = m_owner ? s_badd : s_aadd;
          m_cctl = m_owner ? s_bctl : s_actl;
          din = m_cdin;
          if (rmode == 2)      m_res = 64'hFFFF_FFFF_FFFF_FFFF;
          else if (rmode == 1) m_res = din ^ m_cadd;
          else                 m_res = din;
          m_grant = cyc;
          if (k <= TO) begin m_done = cyc + 1 + k;  m_to = 0; end
          else         begin m_done = cyc + 1 + TO; m_to = 1; m_res = '0; end
        end
        if (cyc == m_done) begin
          if (m_owner) m_bdout = m_res; else m_adout = m_res;
          m_last = m_owner;
          $display("txn cycle=%0d owner=%s result=%h timeout=%0d", cyc, m_owner ? "B" : "A", m_res, m_to);
        end
        if (cyc == m_done + 1) m_cctl = '0;
      end
      eg = (cyc == m_grant);
      ed = (cyc == m_done);
      chk("a_grant", a_grant, eg && !m_owner);
      chk("b_grant", b_grant, eg && m_owner);
      chk("core_start", c_start, eg);
      chk("a_done", a_done, ed && !m_owner);
      chk("b_done", b_done, ed && m_owner);
      chk("a_timeout", a_to, ed && !m_owner && m_to);
      chk("b_timeout", b_to, ed && m_owner && m_to);
      chk("busy", busy, (cyc >= m_grant) && (cyc <= m_done));
      chk("a_data_out", a_dout, m_adout);
      chk("b_data_out", b_dout, m_bdout);
      chk("core_data_in", c_din, m_cdin);
      chk("core_add", c_add, m_cadd);
      chk("core_control", c_ctl, m_cctl);
    end
  end

  typedef struct {
    bit          ra, rb;
    int          lat, mode;
    logic [63:0] din, add;
    logic [31:0] ctl;
    bit          exp_b;
    int          exp_lat;
    bit          exp_to;
    logic [63:0] exp_data;
  } vec_t;

  vec_t tbl [7];

  initial begin : driver
    int  l, n;
    bit  got;
    int  order [4];
    tbl[0] = '{1, 0, 1, 0, 64'h0123_4567_89AB_CDEF, 64'h0, 32'h1, 0, 2, 0, 64'h0123_4567_89AB_CDEF};
    tbl[1] = '{1, 1, 1, 0, 64'h1111_1111_1111_1111, 64'h0, 32'h2, 1, 2, 0, 64'hEEEE_EEEE_EEEE_EEEE};
    tbl[2] = '{1, 1, 5, 1, 64'hA5A5_A5A5_A5A5_A5A5, 64'h0000_0000_FFFF_FFFF, 32'h3, 0, 6, 0, 64'hA5A5_A5A5_5A5A_5A5A};
    tbl[3] = '{0, 1, 255, 0, 64'h2222_2222_2222_2222, 64'h0, 32'h4, 1, TO + 1, 1, 64'h0};
    tbl[4] = '{1, 0, 0, 2, 64'h3333_3333_3333_3333, 64'h0, 32'h5, 0, 2, 0, 64'hFFFF_FFFF_FFFF_FFFF};
    tbl[5] = '{1, 1, TO, 0, 64'h0000_0000_0000_0042, 64'h0, 32'h6, 1, TO + 1, 0, 64'hFFFF_FFFF_FFFF_FFBD};
    tbl[6] = '{1, 1, TO + 1, 0, 64'h4444_4444_4444_4444, 64'h0, 32'h7, 0, TO + 1, 1, 64'h0};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      a_req = tbl[i].ra; b_req = tbl[i].rb; dir_lat = tbl[i].lat; rmode = tbl[i].mode;
      a_din = tbl[i].din;  a_add = tbl[i].add; a_ctl = tbl[i].ctl;
      b_din = ~tbl[i].din; b_add = tbl[i].add; b_ctl = tbl[i].ctl;
      got = 0;
      for (int w = 0; w < 20; w++) begin
        @(negedge clk);
        if (a_grant || b_grant) begin got = 1; break; end
      end
      chk("vec_grant_seen", got, 1);
      if (got) begin
        chk("vec_owner", b_grant, tbl[i].exp_b);
        // owner withdraws and scrambles operands; the operation must still complete unchanged
        if (b_grant) b_req = 0; else a_req = 0;
        a_din = {$urandom, $urandom}; b_din = {$urandom, $urandom};
        a_ctl = ~a_ctl; b_ctl = ~b_ctl;
        got = 0; l = 0;
        for (int w = 0; w < 30; w++) begin
          @(negedge clk);
          l++;
          if (a_done || b_done) begin got = 1; break; end
        end
        chk("vec_done_seen", got, 1);
        chk("vec_latency", l, tbl[i].exp_lat);
        chk("vec_done_owner", b_done, tbl[i].exp_b);
        chk("vec_timeout", a_to | b_to, tbl[i].exp_to);
        chk("vec_data", tbl[i].exp_b ? b_dout : a_dout, tbl[i].exp_data);
        $display("vector %0d owner=%s cycles=%0d timeout=%0d", i, b_done ? "B" : "A", l, a_to | b_to);
      end
      a_req = 0; b_req = 0;
    end

    // Reset pulsed during WAIT: immediate clear, no done, A first afterwards.
    @(negedge clk);
    rmode = 0; dir_lat = 255; a_req = 1; a_din = 64'h5A5A_0000_1234_5678; a_ctl = 32'h9;
    got = 0;
    for (int w = 0; w < 20; w++) begin
      @(negedge clk);
      if (a_grant) begin got = 1; break; end
    end
    chk("rst_seq_grant_seen", got, 1);
    repeat (3) @(negedge clk);
    chk("rst_seq_busy_before", busy, 1);
    rst_n = 0;
    #1;
    chk("rst_async_busy", busy, 0);
    chk("rst_async_core_data_in", c_din, 0);
    chk("rst_async_core_control", c_ctl, 0);
    chk("rst_async_b_data_out", b_dout, 0);
    chk("rst_async_a_done", a_done, 0);
    b_req = 1; dir_lat = 2;
    repeat (2) @(negedge clk);
    rst_n = 1;

    // Both holding req: grants must strictly alternate starting with A.
    n = 0;
    for (int w = 0; w < 200 && n < 4; w++) begin
      @(negedge clk);
      if (a_grant) begin order[n] = 0; n++; end
      else if (b_grant) begin order[n] = 1; n++; end
    end
    chk("alt_grant_count", n, 4);
    for (int i = 0; i < 4; i++) chk("alt_grant_order", order[i], i % 2);
    a_req = 0; b_req = 0;
    repeat (12) @(negedge clk);

    // Randomized traffic against the model.
    rmode = 1; rand_lat = 1;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) a_req = ~a_req;
      if ($urandom_range(0, 3) == 0) b_req = ~b_req;
      a_din = {$urandom, $urandom}; a_add = {$urandom, $urandom}; a_ctl = $urandom;
      b_din = {$urandom, $urandom}; b_add = {$urandom, $urandom}; b_ctl = $urandom;
    end
    a_req = 0; b_req = 0;
    repeat (15) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #100000;
    failures++;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
